// File: rtl/xyzw_rnd_config_loader_if.sv
// Parallel RND word handshake between the DSP configuration controller
// and the RND chain loader, plus the readback word returned to it.
interface xyzw_rnd_config_loader_if #(
    parameter int CHAIN_WIDTH = 48
);
    logic [CHAIN_WIDTH-1:0] cfg_data;
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [CHAIN_WIDTH-1:0] readback;
    logic                   readback_valid;
    logic                   busy;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready,
        input  readback,
        input  readback_valid,
        input  busy
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready,
        output readback,
        output readback_valid,
        output busy
    );
endinterface

// File: rtl/xyzw_rnd_config_loader.sv
// Shifts an RND word MSB-first into the XYZW mux config chain, captures the
// displaced old contents, and masks W=RND selects while the chain moves.
module xyzw_rnd_config_loader #(
    parameter int CHAIN_WIDTH = 48,
    parameter int CNT_WIDTH   = $clog2(CHAIN_WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    xyzw_rnd_config_loader_if.slave cfg,
    output logic                    configuration_input,
    output logic                    configuration_enable,
    input  logic                    configuration_output,
    input  logic [8:0]              opmode_in,
    output logic [8:0]              opmode_out,
    output logic                    rnd_hazard
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(CHAIN_WIDTH - 1);

    state_t                 state;
    logic [CNT_WIDTH-1:0]   count;
    logic [CHAIN_WIDTH-1:0] sreg;
    logic [CHAIN_WIDTH-1:0] rb_sreg;
    logic [CHAIN_WIDTH-1:0] rb_q;
    logic                   rb_valid_q;
    logic                   busy_q;
    logic                   ready_q;
    logic                   enable_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            sreg       <= '0;
            rb_sreg    <= '0;
            rb_q       <= '0;
            rb_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            enable_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cfg.cfg_valid && ready_q) begin
                        state    <= SHIFT;
                        sreg     <= cfg.cfg_data;
                        count    <= '0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        enable_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    sreg    <= sreg << 1;
                    rb_sreg <= {rb_sreg[CHAIN_WIDTH-2:0], configuration_output};
                    count   <= count + CNT_WIDTH'(1);
                    // The tail bit arriving on this last edge completes the old word
                    if (count == LAST) begin
                        state      <= DONE;
                        rb_q       <= {rb_sreg[CHAIN_WIDTH-2:0], configuration_output};
                        rb_valid_q <= 1'b1;
                        enable_q   <= 1'b0;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    rb_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    ready_q    <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign configuration_enable = enable_q;
    assign configuration_input  = (state == SHIFT) && sreg[CHAIN_WIDTH-1];

    assign cfg.cfg_ready      = ready_q;
    assign cfg.busy           = busy_q;
    assign cfg.readback       = rb_q;
    assign cfg.readback_valid = rb_valid_q;

    // RND is only in motion during SHIFT; W=RND would see garbage there
    always_comb begin
        opmode_out = opmode_in;
        rnd_hazard = 1'b0;
        if ((state == SHIFT) && (opmode_in[8:7] == 2'b10)) begin
            opmode_out[8:7] = 2'b00;
            rnd_hazard      = 1'b1;
        end
    end
endmodule

// File: tb/tb_xyzw_rnd_config_loader.sv
// Bench for the RND chain loader: external chain model, directed loads,
// OPMODE vector table, randomized traffic vs. a transaction-level model.
module tb_xyzw_rnd_config_loader;
    localparam int W  = 48;
    localparam int W8 = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    xyzw_rnd_config_loader_if #(.CHAIN_WIDTH(W))  bus ();
    xyzw_rnd_config_loader_if #(.CHAIN_WIDTH(W8)) bus8 ();

    logic       cin, cen, cout, haz;
    logic       cin8, cen8, cout8, haz8;
    logic [8:0] op_in, op_out, op_in8, op_out8;

    xyzw_rnd_config_loader #(.CHAIN_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .cfg(bus),
        .configuration_input(cin), .configuration_enable(cen),
        .configuration_output(cout),
        .opmode_in(op_in), .opmode_out(op_out), .rnd_hazard(haz)
    );

    xyzw_rnd_config_loader #(.CHAIN_WIDTH(W8)) dut8 (
        .clk(clk), .reset(reset), .cfg(bus8),
        .configuration_input(cin8), .configuration_enable(cen8),
        .configuration_output(cout8),
        .opmode_in(op_in8), .opmode_out(op_out8), .rnd_hazard(haz8)
    );

    // External RND chains: shift left, new bit into LSB, tail is MSB
    logic [W-1:0]  chain48, pre48_val;
    logic [W8-1:0] chain8, pre8_val;
    logic          pre_en;

    always @(posedge clk) begin
        if (pre_en) chain48 <= pre48_val;
        else if (cen) chain48 <= {chain48[W-2:0], cin};
    end
    always @(posedge clk) begin
        if (pre_en) chain8 <= pre8_val;
        else if (cen8) chain8 <= {chain8[W8-2:0], cin8};
    end
    assign cout  = chain48[W-1];
    assign cout8 = chain8[W8-1];

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Transaction-level model state for the random phase
    int           ph;
    logic [W-1:0] pend, chain_m, rb_m;

    task automatic load48(input logic [W-1:0] d, output int en_n,
                          output int rbv_at, output logic [W-1:0] rb);
        @(negedge clk);
        chk("ready_before_accept", bus.cfg_ready, 1);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = d;
        @(posedge clk);
        #1;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = ~d;
        en_n = 0;
        rbv_at = 0;
        rb = '0;
        for (int i = 1; i <= W + 6; i++) begin
            @(negedge clk);
            if (cen) en_n++;
            if (bus.readback_valid && rbv_at == 0) begin
                rbv_at = i;
                rb = bus.readback;
            end
        end
    endtask

    task automatic rand_cycle(input bit allow);
        logic [8:0] op, e_op;
        bit shifting;
        @(negedge clk);
        shifting = (ph >= 0) && (ph < W);
        chk("rnd_enable", cen, shifting);
        chk("rnd_ready", bus.cfg_ready, ph < 0);
        chk("rnd_busy", bus.busy, ph >= 0);
        chk("rnd_rbv", bus.readback_valid, ph == W);
        if (ph == W) begin
            chk("rnd_readback", bus.readback, chain_m);
            chk("rnd_chain", chain48, pend);
            rb_m = chain_m;
            chain_m = pend;
        end else begin
            chk("rnd_rb_hold", bus.readback, rb_m);
        end
        bus.cfg_valid = allow && ($urandom_range(0, 2) == 0);
        bus.cfg_data  = 48'({$urandom(), $urandom()});
        op = 9'($urandom());
        if ($urandom_range(0, 1) == 1) op[8:7] = 2'b10;
        op_in = op;
        e_op = (shifting && op[8:7] == 2'b10) ? {2'b00, op[6:0]} : op;
        #1;
        chk("rnd_opmode", op_out, e_op);
        chk("rnd_hazard", haz, shifting && op[8:7] == 2'b10);
        @(posedge clk);
        if (ph < 0) begin
            if (bus.cfg_valid) begin
                ph = 0;
                pend = bus.cfg_data;
            end
        end else if (ph == W) begin
            ph = -1;
        end else begin
            ph++;
        end
    endtask

    typedef struct {
        logic [8:0] op;
        bit         shift;
        logic [8:0] exp;
        logic       hz;
    } ovec_t;

    ovec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int en_n, rbv_at, nrb, rdy_at, nrbv, ks;
        bit drop, found;
        logic [W-1:0] rb, rbs[2];
        logic [W8-1:0] rb8;

        tbl[0] = '{9'b1_0000_0101, 1'b1, 9'b0_0000_0101, 1'b1};
        tbl[1] = '{9'b1_1000_0101, 1'b1, 9'b1_1000_0101, 1'b0};
        tbl[2] = '{9'b0_1111_1111, 1'b1, 9'b0_1111_1111, 1'b0};
        tbl[3] = '{9'b1_0111_1010, 1'b1, 9'b0_0111_1010, 1'b1};
        tbl[4] = '{9'b1_0000_0101, 1'b0, 9'b1_0000_0101, 1'b0};
        tbl[5] = '{9'b1_0111_1010, 1'b0, 9'b1_0111_1010, 1'b0};

        bus.cfg_valid  = 1'b0;
        bus.cfg_data   = '0;
        bus8.cfg_valid = 1'b0;
        bus8.cfg_data  = '0;
        op_in  = 9'b1_0000_0101;
        op_in8 = 9'h000;
        pre_en = 1'b1;
        pre48_val = '0;
        pre8_val  = 8'h5A;

        // Reset state, sampled mid-cycle
        #12;
        chk("rst_ready", bus.cfg_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_enable", cen, 0);
        chk("rst_cin", cin, 0);
        chk("rst_readback", bus.readback, 0);
        chk("rst_rbv", bus.readback_valid, 0);
        chk("rst_opmode", op_out, 9'b1_0000_0101);
        chk("rst_hazard", haz, 0);
        chk("rst_ready8", bus8.cfg_ready, 1);
        @(negedge clk);
        reset  = 1'b0;
        pre_en = 1'b0;

        // Single load over an all-zero chain
        load48(48'hA5A5_0123_4567, en_n, rbv_at, rb);
        chk("single_en_cycles", en_n, W);
        chk("single_rbv_at", rbv_at, W + 1);
        chk("single_readback", rb, 0);
        chk("single_chain", chain48, 48'hA5A5_0123_4567);
        chk("single_rb_hold", bus.readback, 0);

        // Back-to-back loads with cfg_valid held high
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 48'hFFFF_0000_FFFF;
        @(posedge clk);
        #1 bus.cfg_data = 48'h1234_5678_9ABC;
        en_n = 0; nrb = 0; rdy_at = 0; drop = 0;
        for (int i = 1; i <= 2 * W + 10; i++) begin
            @(negedge clk);
            if (drop) bus.cfg_valid = 1'b0;
            if (cen) en_n++;
            if (bus.readback_valid) begin
                if (nrb < 2) rbs[nrb] = bus.readback;
                nrb++;
            end
            if (bus.cfg_ready && rdy_at == 0) begin
                rdy_at = i;
                drop = 1;
            end
        end
        chk("b2b_ready_at", rdy_at, W + 2);
        chk("b2b_en_cycles", en_n, 2 * W);
        chk("b2b_rbv_count", nrb, 2);
        chk("b2b_readback0", rbs[0], 48'hA5A5_0123_4567);
        chk("b2b_readback1", rbs[1], 48'hFFFF_0000_FFFF);
        chk("b2b_chain", chain48, 48'h1234_5678_9ABC);

        // OPMODE vector table: SHIFT rows during a load, then DONE, then IDLE
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 48'h0F0F_F0F0_3C3C;
        @(posedge clk);
        #1 bus.cfg_valid = 1'b0;
        ks = 0;
        for (int k = 0; k < 6; k++) begin
            if (tbl[k].shift) begin
                @(negedge clk);
                ks++;
                op_in = tbl[k].op;
                #1;
                chk("tbl_shift_enable", cen, 1);
                chk("tbl_shift_opmode", op_out, tbl[k].exp);
                chk("tbl_shift_hazard", haz, tbl[k].hz);
            end
        end
        op_in = 9'b1_0000_0101;
        found = 0;
        for (int i = ks + 1; i <= W + 6; i++) begin
            @(negedge clk);
            if (bus.readback_valid && !found) begin
                found = 1;
                #1;
                chk("done_opmode", op_out, 9'b1_0000_0101);
                chk("done_hazard", haz, 0);
                chk("tbl_readback", bus.readback, 48'h1234_5678_9ABC);
            end
        end
        chk("tbl_rbv_seen", found, 1);
        chk("tbl_chain", chain48, 48'h0F0F_F0F0_3C3C);
        for (int k = 0; k < 6; k++) begin
            if (!tbl[k].shift) begin
                @(negedge clk);
                op_in = tbl[k].op;
                #1;
                chk("tbl_idle_ready", bus.cfg_ready, 1);
                chk("tbl_idle_opmode", op_out, tbl[k].exp);
                chk("tbl_idle_hazard", haz, tbl[k].hz);
            end
        end

        // Randomized traffic against the transaction model
        ph = -1;
        chain_m = 48'h0F0F_F0F0_3C3C;
        rb_m = 48'h1234_5678_9ABC;
        for (int c = 0; c < 400; c++) rand_cycle(1'b1);
        for (int c = 0; c < W + 4; c++) rand_cycle(1'b0);
        bus.cfg_valid = 1'b0;

        // Asynchronous reset in the middle of SHIFT
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 48'hDEAD_BEEF_CAFE;
        @(posedge clk);
        #1 bus.cfg_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_reset_enable", cen, 1);
        chk("pre_reset_readback", bus.readback, rb_m);
        op_in = 9'b1_0000_0101;
        #2 reset = 1'b1;
        #1;
        chk("midrst_enable", cen, 0);
        chk("midrst_cin", cin, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_ready", bus.cfg_ready, 1);
        chk("midrst_readback", bus.readback, 0);
        chk("midrst_rbv", bus.readback_valid, 0);
        chk("midrst_opmode", op_out, 9'b1_0000_0101);
        chk("midrst_hazard", haz, 0);
        @(negedge clk);
        reset = 1'b0;
        nrbv = 0;
        for (int i = 0; i < W + 10; i++) begin
            @(negedge clk);
            if (bus.readback_valid) nrbv++;
        end
        chk("aborted_no_rbv", nrbv, 0);
        load48(48'h0123_4567_89AB, en_n, rbv_at, rb);
        chk("reload_en_cycles", en_n, W);
        chk("reload_rbv_at", rbv_at, W + 1);
        chk("reload_chain", chain48, 48'h0123_4567_89AB);

        // Narrow chain: 8'hC3 over 8'h5A
        @(negedge clk);
        chk("w8_ready", bus8.cfg_ready, 1);
        bus8.cfg_valid = 1'b1;
        bus8.cfg_data  = 8'hC3;
        @(posedge clk);
        #1;
        bus8.cfg_valid = 1'b0;
        bus8.cfg_data  = 8'h00;
        en_n = 0; rbv_at = 0; rb8 = '0;
        for (int i = 1; i <= W8 + 6; i++) begin
            @(negedge clk);
            if (cen8) en_n++;
            if (bus8.readback_valid && rbv_at == 0) begin
                rbv_at = i;
                rb8 = bus8.readback;
            end
        end
        chk("w8_en_cycles", en_n, W8);
        chk("w8_rbv_at", rbv_at, W8 + 1);
        chk("w8_readback", rb8, 8'h5A);
        chk("w8_chain", chain8, 8'hC3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/xyzw_rnd_config_loader.md
Name: xyzw_rnd_config_loader

Overview:
- Sequencer for the serial RND configuration chain of the XYZW operand mux, where the W operand can select the 48-bit RND constant.
- Accepts a parallel RND word through a valid/ready handshake and shifts it MSB-first into the chain over CHAIN_WIDTH cycles.
- Captures the displaced old chain contents as a readback word.
- Masks any OPMODE that selects W=RND while the chain is shifting.
- Sits between the DSP-slice configuration controller and the XYZW mux.

Parameters:
- CHAIN_WIDTH, 48: number of chain bits shifted per load. Minimum 2. Equals the RND width for a single slice.
- CNT_WIDTH, $clog2(CHAIN_WIDTH): bit-counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- cfg_data  input  CHAIN_WIDTH  new RND word; bit CHAIN_WIDTH-1 is shifted first.
- cfg_valid  input  1  cfg_data is valid.
- cfg_ready  output  1  loader can accept a word.
- readback  output  CHAIN_WIDTH  previous chain contents, captured during the last load.
- readback_valid  output  1  one-cycle pulse; readback is updated.
- busy  output  1  load in progress (SHIFT or DONE).
- configuration_input  output  1  serial data to the chain.
- configuration_enable  output  1  chain shift enable.
- configuration_output  input  1  chain tail bit (RND[CHAIN_WIDTH-1]).
- opmode_in  input  9  OPMODE from the sequencer.
- opmode_out  output  9  OPMODE delivered to the XYZW mux.
- rnd_hazard  output  1  the W=RND select is being masked this cycle.

Behaviour:
- Chain semantics (fixed): each enabled cycle does RND <= {RND[CHAIN_WIDTH-2:0], configuration_input}.
  - Shifting the word MSB-first for CHAIN_WIDTH enabled cycles leaves RND == cfg_data.
- States:
  - IDLE: cfg_ready=1, busy=0, configuration_enable=0.
  - SHIFT: configuration_enable=1, busy=1, cfg_ready=0.
  - DONE: configuration_enable=0, busy=1, cfg_ready=0, readback_valid=1.
- Transitions:
  - IDLE -> SHIFT on the edge where cfg_valid&cfg_ready. At that edge, latch cfg_data into shift register sreg and clear count.
  - SHIFT:
    - configuration_input = sreg[CHAIN_WIDTH-1].
    - At each edge: sreg <= sreg<<1; rb_sreg <= {rb_sreg[CHAIN_WIDTH-2:0], configuration_output}; count increments.
    - The edge with count==CHAIN_WIDTH-1 moves to DONE and loads readback from the final rb_sreg value.
  - DONE -> IDLE unconditionally after 1 cycle.
- Latency and throughput:
  - Exactly CHAIN_WIDTH consecutive enabled cycles per load.
  - Accept edge to readback_valid: CHAIN_WIDTH+1 cycles.
  - Next accept no earlier than the edge following DONE, so back-to-back period is CHAIN_WIDTH+2 cycles.
- Handshake:
  - cfg_data is sampled only on the accept edge and may change afterwards.
  - cfg_valid asserted outside IDLE is ignored and held off, not lost; no word is dropped.
- Readback:
  - During SHIFT, configuration_output presents the old chain bits MSB-first.
  - After DONE, readback equals the chain contents prior to the load.
  - readback holds its value until the next DONE.
- OPMODE masking:
  - opmode_out = opmode_in, except when state==SHIFT and opmode_in[8:7]==2'b10. In that case opmode_out[8:7]=2'b00 (W=0) and rnd_hazard=1.
  - Combinational; no added latency.
  - No masking in DONE or IDLE, because RND is stable there.
  - Other OPMODE bits always pass unchanged.
- Driving the chain outputs:
  - configuration_enable and configuration_input are decoded only from state flops and sreg (no combinational path from cfg_valid).
- Reset values: state=IDLE, count=0, sreg=0, rb_sreg=0, readback=0, readback_valid=0, busy=0, configuration_enable=0, configuration_input=0.
  - Reset does not clear cfg_ready; it is 1 in IDLE.
- Reset mid-SHIFT:
  - All outputs return to their reset values immediately (asynchronous).
  - Chain contents are then partially shifted and undefined; software must reload.
  - No readback_valid is issued for the aborted load.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> cfg_ready=1, busy=0, configuration_enable=0, readback=0, opmode_out==opmode_in immediately.
- Single load: chain model preloaded with 48'h0; load 48'hA5A5_0123_4567 -> enable high for exactly 48 cycles; chain model == 48'hA5A5_0123_4567; readback_valid pulse at accept+49 with readback=48'h0.
- Back-to-back loads: cfg_valid held high; load 48'hFFFF_0000_FFFF then 48'h1234_5678_9ABC -> second accept on the edge after DONE; second readback=48'hFFFF_0000_FFFF; final chain=48'h1234_5678_9ABC; no dropped word.
- OPMODE masking:
  - opmode_in=9'b1_0000_0101 during SHIFT -> opmode_out=9'b0_0000_0101 and rnd_hazard=1.
  - Same input in IDLE -> passes unmodified, rnd_hazard=0.
  - opmode_in=9'b1_1000_0101 during SHIFT -> passes unmodified.
- Reset mid-SHIFT: assert reset at shift cycle 20 -> configuration_enable drops without waiting for clk; no readback_valid; a fresh load afterwards completes in 48 enabled cycles.
- CHAIN_WIDTH=8: load 8'hC3 over prior chain 8'h5A -> 8 enabled cycles; chain=8'hC3; readback=8'h5A at accept+9.
